// File: rtl/simplex_loader.sv
// Streams a linear-program frame into parallel problem registers, starts the solver,
// then returns the solver's solution vector as a result stream.
module simplex_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int NCOEFMAX   = 2,
  parameter int NREQMAX    = 1,
  parameter int NRLEQMAX   = 1
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic [DATA_WIDTH-1:0]                              s_data_i,
  input  logic                                               s_valid_i,
  input  logic                                               s_last_i,
  output logic                                               s_ready_o,
  output logic [NCOEFMAX-1:0][DATA_WIDTH-1:0]                f_o,
  output logic [NCOEFMAX-1:0][DATA_WIDTH-1:0]                LB_o,
  output logic [NCOEFMAX-1:0][DATA_WIDTH-1:0]                UB_o,
  output logic [NRLEQMAX-1:0][NCOEFMAX-1:0][DATA_WIDTH-1:0]  Aleq_o,
  output logic [NRLEQMAX-1:0][DATA_WIDTH-1:0]                bleq_o,
  output logic [NREQMAX-1:0][NCOEFMAX-1:0][DATA_WIDTH-1:0]   Aeq_o,
  output logic [NREQMAX-1:0][DATA_WIDTH-1:0]                 beq_o,
  output logic [7:0]                                         ncoef_o,
  output logic [7:0]                                         nreq_o,
  output logic [7:0]                                         nrleq_o,
  output logic                                               start_o,
  input  logic                                               done_i,
  input  logic [NCOEFMAX-1:0][DATA_WIDTH-1:0]                sol_i,
  output logic [DATA_WIDTH-1:0]                              m_data_o,
  output logic                                               m_valid_o,
  output logic                                               m_last_o,
  input  logic                                               m_ready_i,
  output logic                                               busy_o,
  output logic                                               err_o
);

  localparam int OFF_F    = 1;
  localparam int OFF_ALEQ = OFF_F + NCOEFMAX;
  localparam int OFF_BLEQ = OFF_ALEQ + NRLEQMAX * NCOEFMAX;
  localparam int OFF_AEQ  = OFF_BLEQ + NRLEQMAX;
  localparam int OFF_BEQ  = OFF_AEQ + NREQMAX * NCOEFMAX;
  localparam int OFF_LB   = OFF_BEQ + NREQMAX;
  localparam int OFF_UB   = OFF_LB + NCOEFMAX;
  localparam int W        = OFF_UB + NCOEFMAX;
  localparam int IW       = $clog2(W);
  localparam int KW       = (NCOEFMAX > 1) ? $clog2(NCOEFMAX) : 1;

  typedef enum logic [2:0] {LOAD, DISCARD, START, WAIT, SEND} state_t;

  state_t                               state_q, state_d;
  logic [IW-1:0]                        idx_q, idx_d;
  logic [KW-1:0]                        k_q, k_d;
  logic                                 err_d;
  logic [NCOEFMAX-1:0][DATA_WIDTH-1:0]  buf_q;
  logic                                 load_we;
  logic                                 capture_we;
  logic                                 header_ok;
  logic                                 k_last;

  assign load_we    = (state_q == LOAD) && s_valid_i;
  assign capture_we = (state_q == WAIT) && done_i;
  assign k_last     = (k_q == KW'(NCOEFMAX - 1));
  assign header_ok  = (ncoef_o != 8'd0) && (ncoef_o <= 8'(NCOEFMAX)) &&
                      (nreq_o <= 8'(NREQMAX)) && (nrleq_o <= 8'(NRLEQMAX));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LOAD;
      idx_q   <= '0;
      k_q     <= '0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      err_o   <= err_d;
    end
  end

  // Header validity is judged only at end of frame, from the registered header fields.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    k_d     = k_q;
    err_d   = 1'b0;
    case (state_q)
      LOAD: begin
        if (s_valid_i) begin
          if (idx_q == IW'(W - 1)) begin
            idx_d = '0;
            if (s_last_i) begin
              if (header_ok) state_d = START;
              else           err_d   = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = DISCARD;
            end
          end else if (s_last_i) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DISCARD: begin
        if (s_valid_i && s_last_i) state_d = LOAD;
      end
      START: state_d = WAIT;
      WAIT: begin
        if (done_i) begin
          state_d = SEND;
          k_d     = '0;
        end
      end
      SEND: begin
        if (m_ready_i) begin
          if (k_last) begin
            state_d = LOAD;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    s_ready_o = (state_q == LOAD) || (state_q == DISCARD);
    busy_o    = (state_q != LOAD);
    start_o   = (state_q == START);
    m_valid_o = (state_q == SEND);
    m_last_o  = (state_q == SEND) && k_last;
    m_data_o  = (state_q == SEND) ? buf_q[k_q] : '0;
  end

  // Each accepted word lands in the register addressed by its position in the frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f_o     <= '0;
      LB_o    <= '0;
      UB_o    <= '0;
      Aleq_o  <= '0;
      bleq_o  <= '0;
      Aeq_o   <= '0;
      beq_o   <= '0;
      ncoef_o <= '0;
      nreq_o  <= '0;
      nrleq_o <= '0;
      buf_q   <= '0;
    end else begin
      if (load_we) begin
        if (idx_q == '0) begin
          ncoef_o <= s_data_i[7:0];
          nreq_o  <= s_data_i[15:8];
          nrleq_o <= s_data_i[23:16];
        end
        for (int c = 0; c < NCOEFMAX; c++) begin
          if (idx_q == IW'(OFF_F + c))  f_o[c]  <= s_data_i;
          if (idx_q == IW'(OFF_LB + c)) LB_o[c] <= s_data_i;
          if (idx_q == IW'(OFF_UB + c)) UB_o[c] <= s_data_i;
        end
        for (int r = 0; r < NRLEQMAX; r++) begin
          for (int c = 0; c < NCOEFMAX; c++) begin
            if (idx_q == IW'(OFF_ALEQ + r * NCOEFMAX + c)) Aleq_o[r][c] <= s_data_i;
          end
          if (idx_q == IW'(OFF_BLEQ + r)) bleq_o[r] <= s_data_i;
        end
        for (int r = 0; r < NREQMAX; r++) begin
          for (int c = 0; c < NCOEFMAX; c++) begin
            if (idx_q == IW'(OFF_AEQ + r * NCOEFMAX + c)) Aeq_o[r][c] <= s_data_i;
          end
          if (idx_q == IW'(OFF_BEQ + r)) beq_o[r] <= s_data_i;
        end
      end
      if (capture_we) buf_q <= sol_i;
    end
  end

endmodule

// File: tb/tb_simplex_loader.sv
// Directed self-checking bench for simplex_loader: frame loading, error framing,
// result streaming with backpressure, and mid-stream reset.
module tb_simplex_loader;

  localparam int DW = 32;
  localparam int NC = 2;
  localparam int NQ = 1;
  localparam int NL = 1;

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  logic [DW-1:0]               s_data_i;
  logic                        s_valid_i;
  logic                        s_last_i;
  logic                        s_ready_o;
  logic [NC-1:0][DW-1:0]       f_o, LB_o, UB_o;
  logic [NL-1:0][NC-1:0][DW-1:0] Aleq_o;
  logic [NL-1:0][DW-1:0]       bleq_o;
  logic [NQ-1:0][NC-1:0][DW-1:0] Aeq_o;
  logic [NQ-1:0][DW-1:0]       beq_o;
  logic [7:0]                  ncoef_o, nreq_o, nrleq_o;
  logic                        start_o;
  logic                        done_i;
  logic [NC-1:0][DW-1:0]       sol_i;
  logic [DW-1:0]               m_data_o;
  logic                        m_valid_o;
  logic                        m_last_o;
  logic                        m_ready_i;
  logic                        busy_o;
  logic                        err_o;

  int checks = 0;
  int fails = 0;
  int startCount = 0;
  int errCount = 0;
  int s0, e0;
  logic [31:0] frame [0:12];

  always #5 clk_i = ~clk_i;

  simplex_loader #(.DATA_WIDTH(DW), .NCOEFMAX(NC), .NREQMAX(NQ), .NRLEQMAX(NL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .f_o(f_o), .LB_o(LB_o), .UB_o(UB_o),
    .Aleq_o(Aleq_o), .bleq_o(bleq_o), .Aeq_o(Aeq_o), .beq_o(beq_o),
    .ncoef_o(ncoef_o), .nreq_o(nreq_o), .nrleq_o(nrleq_o),
    .start_o(start_o), .done_i(done_i), .sol_i(sol_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  // Pulse counters sample on the falling edge, clear of the registers' update edge.
  always @(negedge clk_i) begin
    if (start_o) startCount++;
    if (err_o)   errCount++;
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic last);
    s_data_i  = d;
    s_valid_i = 1'b1;
    s_last_i  = last;
    tick;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    s_data_i  = '0;
  endtask

  task automatic pushFrame(input int n, input int lastPos);
    for (int i = 0; i < n; i++) applyStimulus(frame[i], i == lastPos);
  endtask

  task automatic setDefaultFrame;
    frame = '{32'h00010102, 32'h40400000, 32'h40A00000, 32'h3F800000, 32'h40000000,
              32'h41000000, 32'h40400000, 32'h40000000, 32'h41400000, 32'h0,
              32'h0, 32'h41200000, 32'h41200000};
  endtask

  // Called from the WAIT state; streams both result words with ready held high.
  task automatic finishSolve(input logic [31:0] a, input logic [31:0] b);
    sol_i[0]  = a;
    sol_i[1]  = b;
    done_i    = 1'b1;
    m_ready_i = 1'b1;
    tick;
    done_i = 1'b0;
    sol_i  = '0;
    checkOutput("fs_word0", m_data_o, a);
    checkOutput("fs_valid0", m_valid_o, 1);
    tick;
    checkOutput("fs_word1", m_data_o, b);
    checkOutput("fs_last1", m_last_o, 1);
    tick;
    m_ready_i = 1'b0;
    checkOutput("fs_idle", busy_o, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i = 1'b1; s_data_i = '0; s_valid_i = 1'b0; s_last_i = 1'b0;
    done_i = 1'b0; sol_i = '0; m_ready_i = 1'b0;
    setDefaultFrame;
    tick; tick;
    rst_i = 1'b0;
    checkOutput("rst_ready", s_ready_o, 1);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_start", start_o, 0);
    checkOutput("rst_mvalid", m_valid_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_ncoef", ncoef_o, 0);
    checkOutput("rst_f0", f_o[0], 0);

    // Nominal load and solve
    $display("[TB] nominal frame");
    pushFrame(13, 12);
    checkOutput("t1_start", start_o, 1);
    checkOutput("t1_f0", f_o[0], 32'h40400000);
    checkOutput("t1_f1", f_o[1], 32'h40A00000);
    checkOutput("t1_aleq00", Aleq_o[0][0], 32'h3F800000);
    checkOutput("t1_aleq01", Aleq_o[0][1], 32'h40000000);
    checkOutput("t1_bleq", bleq_o[0], 32'h41000000);
    checkOutput("t1_aeq00", Aeq_o[0][0], 32'h40400000);
    checkOutput("t1_aeq01", Aeq_o[0][1], 32'h40000000);
    checkOutput("t1_beq", beq_o[0], 32'h41400000);
    checkOutput("t1_lb0", LB_o[0], 32'h0);
    checkOutput("t1_ub1", UB_o[1], 32'h41200000);
    checkOutput("t1_ncoef", ncoef_o, 2);
    checkOutput("t1_nreq", nreq_o, 1);
    checkOutput("t1_nrleq", nrleq_o, 1);
    checkOutput("t1_ready", s_ready_o, 0);
    checkOutput("t1_busy", busy_o, 1);
    done_i = 1'b1;
    sol_i  = {32'hDEADBEEF, 32'hDEADBEEF};
    tick;
    done_i = 1'b0;
    checkOutput("t1_start_off", start_o, 0);
    checkOutput("t1_wait_nv", m_valid_o, 0);
    tick;
    checkOutput("t1_wait_nv2", m_valid_o, 0);
    sol_i[0]  = 32'h40000000;
    sol_i[1]  = 32'h40400000;
    done_i    = 1'b1;
    m_ready_i = 1'b1;
    tick;
    done_i = 1'b0;
    sol_i  = '0;
    checkOutput("t1_mvalid0", m_valid_o, 1);
    checkOutput("t1_mdata0", m_data_o, 32'h40000000);
    checkOutput("t1_mlast0", m_last_o, 0);
    tick;
    checkOutput("t1_mdata1", m_data_o, 32'h40400000);
    checkOutput("t1_mlast1", m_last_o, 1);
    tick;
    m_ready_i = 1'b0;
    checkOutput("t1_back_nv", m_valid_o, 0);
    checkOutput("t1_back_ready", s_ready_o, 1);
    checkOutput("t1_back_busy", busy_o, 0);

    // Backpressure during SEND
    $display("[TB] result backpressure");
    pushFrame(13, 12);
    checkOutput("t2_start", start_o, 1);
    tick;
    sol_i[0] = 32'h40000000;
    sol_i[1] = 32'h40400000;
    done_i   = 1'b1;
    tick;
    done_i = 1'b0;
    sol_i  = '0;
    for (int j = 0; j < 3; j++) begin
      checkOutput("t2_hold0_data", m_data_o, 32'h40000000);
      checkOutput("t2_hold0_last", m_last_o, 0);
      checkOutput("t2_hold0_valid", m_valid_o, 1);
      tick;
    end
    checkOutput("t2_still0", m_data_o, 32'h40000000);
    m_ready_i = 1'b1;
    tick;
    m_ready_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checkOutput("t2_hold1_data", m_data_o, 32'h40400000);
      checkOutput("t2_hold1_last", m_last_o, 1);
      tick;
    end
    m_ready_i = 1'b1;
    tick;
    m_ready_i = 1'b0;
    checkOutput("t2_done_nv", m_valid_o, 0);
    checkOutput("t2_done_busy", busy_o, 0);

    // Early s_last
    $display("[TB] short frame");
    s0 = startCount;
    e0 = errCount;
    pushFrame(6, 5);
    checkOutput("t3_err", err_o, 1);
    checkOutput("t3_nostart", start_o, 0);
    checkOutput("t3_ready", s_ready_o, 1);
    checkOutput("t3_busy", busy_o, 0);
    tick;
    checkOutput("t3_err_pulse", err_o, 0);
    frame[1] = 32'h3F800000;
    pushFrame(13, 12);
    checkOutput("t3_start", start_o, 1);
    checkOutput("t3_f0", f_o[0], 32'h3F800000);
    checkOutput("t3_f1", f_o[1], 32'h40A00000);
    tick;
    finishSolve(32'h3F800000, 32'h40A00000);
    checkOutput("t3_errcount", errCount - e0, 1);
    checkOutput("t3_startcount", startCount - s0, 1);
    setDefaultFrame;

    // Invalid header, then overlong frame
    $display("[TB] bad header and long frame");
    s0 = startCount;
    e0 = errCount;
    frame[0] = 32'h00010103;
    pushFrame(13, 12);
    checkOutput("t4_hdr_err", err_o, 1);
    checkOutput("t4_hdr_nostart", start_o, 0);
    checkOutput("t4_hdr_busy", busy_o, 0);
    checkOutput("t4_hdr_ready", s_ready_o, 1);
    frame[0] = 32'h00010102;
    for (int i = 0; i < 15; i++) begin
      applyStimulus((i < 13) ? frame[i] : 32'h11111111, i == 14);
      if (i == 12) begin
        checkOutput("t4_long_err", err_o, 1);
        checkOutput("t4_long_busy", busy_o, 1);
        checkOutput("t4_long_ready", s_ready_o, 1);
      end
      if (i == 13) begin
        checkOutput("t4_disc_err", err_o, 0);
        checkOutput("t4_disc_busy", busy_o, 1);
        checkOutput("t4_disc_ub1", UB_o[1], 32'h41200000);
        checkOutput("t4_disc_ncoef", ncoef_o, 2);
      end
    end
    checkOutput("t4_end_busy", busy_o, 0);
    checkOutput("t4_end_nostart", start_o, 0);
    tick;
    checkOutput("t4_startcount", startCount - s0, 0);
    checkOutput("t4_errcount", errCount - e0, 2);
    pushFrame(13, 12);
    checkOutput("t4_recover_start", start_o, 1);
    tick;
    finishSolve(32'h40000000, 32'h40400000);

    // Reset in the middle of SEND
    $display("[TB] reset during send");
    pushFrame(13, 12);
    tick;
    sol_i[0]  = 32'h40000000;
    sol_i[1]  = 32'h40400000;
    done_i    = 1'b1;
    m_ready_i = 1'b1;
    tick;
    done_i = 1'b0;
    checkOutput("t5_word0", m_data_o, 32'h40000000);
    tick;
    checkOutput("t5_word1", m_data_o, 32'h40400000);
    rst_i     = 1'b1;
    m_ready_i = 1'b0;
    tick;
    rst_i = 1'b0;
    sol_i = '0;
    checkOutput("t5_mvalid", m_valid_o, 0);
    checkOutput("t5_mdata", m_data_o, 0);
    checkOutput("t5_mlast", m_last_o, 0);
    checkOutput("t5_f0", f_o[0], 0);
    checkOutput("t5_bleq", bleq_o[0], 0);
    checkOutput("t5_ncoef", ncoef_o, 0);
    checkOutput("t5_busy", busy_o, 0);
    checkOutput("t5_start", start_o, 0);
    checkOutput("t5_err", err_o, 0);
    checkOutput("t5_ready", s_ready_o, 1);
    pushFrame(13, 12);
    checkOutput("t5_start_new", start_o, 1);
    checkOutput("t5_f0_new", f_o[0], 32'h40400000);
    tick;
    finishSolve(32'h40400000, 32'h40000000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/simplex_loader.md
SIMPLEX_LOADER -- requirements
Module: simplex_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, float32 word width.
REQ-002 SHALL have parameter NCOEFMAX, default 2, max decision variables.
REQ-003 SHALL have parameter NREQMAX, default 1, max equality rows.
REQ-004 SHALL have parameter NRLEQMAX, default 1, max inequality rows.
REQ-005 SHALL have ports:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- s_data_i  in  DATA_WIDTH  problem stream word.
- s_valid_i  in  1  stream word valid.
- s_last_i  in  1  final word of frame.
- s_ready_o  out  1  loader accepts word.
- f_o, LB_o, UB_o  out  [NCOEFMAX] x DATA_WIDTH  objective, lower bounds, upper bounds.
- Aleq_o  out  [NRLEQMAX][NCOEFMAX] x DATA_WIDTH  inequality matrix; bleq_o  out  [NRLEQMAX] x DATA_WIDTH.
- Aeq_o  out  [NREQMAX][NCOEFMAX] x DATA_WIDTH  equality matrix; beq_o  out  [NREQMAX] x DATA_WIDTH.
- ncoef_o, nreq_o, nrleq_o  out  8 each  active sizes.
- start_o  out  1  solver start.
- done_i  in  1  solver finished.
- sol_i  in  [NCOEFMAX] x DATA_WIDTH  solver solution.
- m_data_o  out  DATA_WIDTH  result word; m_valid_o  out  1; m_last_o  out  1; m_ready_i  in  1.
- busy_o  out  1  high outside LOAD; err_o  out  1  one-cycle frame-error pulse.

Function
REQ-006 Frame SHALL be exactly W = 1 + 3*NCOEFMAX + NRLEQMAX*(NCOEFMAX+1) + NREQMAX*(NCOEFMAX+1) words (13 at defaults), in order: header, f, Aleq row-major, bleq, Aeq row-major, beq, LB, UB.
REQ-007 Header SHALL hold ncoef [7:0], nreq [15:8], nrleq [23:16]; bits [31:24] ignored.
REQ-008 FSM states SHALL be LOAD, DISCARD, START, WAIT, SEND.
REQ-009 LOAD: s_ready_o=1; word accepted when s_valid_i&s_ready_o; word index counter increments per accept; word written to its output register in the accepting cycle.
REQ-010 Accept of word W-1 with s_last_i=1 and valid header SHALL go to START; start_o high the next cycle for exactly one cycle, then WAIT.
REQ-011 Header invalid (ncoef=0, ncoef>NCOEFMAX, nreq>NREQMAX, nrleq>NRLEQMAX) SHALL, at end of frame, pulse err_o, skip START, return to LOAD with index 0.
REQ-012 s_last_i=1 on index<W-1 SHALL pulse err_o, reset index to 0, stay in LOAD; no start.
REQ-013 s_last_i=0 on index W-1 SHALL pulse err_o, enter DISCARD (s_ready_o=1, words dropped) until a word with s_last_i=1 is accepted, then LOAD.
REQ-014 Problem output registers SHALL change only in LOAD and hold stable through START, WAIT, SEND.
REQ-015 WAIT: s_ready_o=0; first cycle with done_i=1 SHALL capture sol_i into internal buffer and enter SEND; done_i ignored in every other state, including the START cycle.
REQ-016 SEND: m_valid_o=1 with m_data_o=buffer[k], k=0..NCOEFMAX-1, m_last_o=1 only at k=NCOEFMAX-1; data/last stable while m_ready_i=0; k advances on m_valid_o&m_ready_i.
REQ-017 Handshake of last result word SHALL return FSM to LOAD next cycle, index 0.
REQ-018 Latency: last word accepted cycle T -> start_o cycle T+1; done_i sampled cycle D -> m_valid_o cycle D+1.
REQ-019 busy_o=1 in DISCARD, START, WAIT, SEND.

Reset
REQ-020 rst_i sampled high SHALL, at any state including mid-frame or mid-SEND, force LOAD, index 0, k 0, all problem registers and result buffer 0, sizes 0, start_o/m_valid_o/m_last_o/err_o/busy_o 0, s_ready_o 1 after release.

Verification
REQ-021 Frame {00010102, 40400000, 40A00000, 3F800000, 40000000, 41000000, 40400000, 40000000, 41400000, 0, 0, 41200000, 41200000}, s_last_i on word 12 -> f_o={3.0,5.0}, bleq_o=8.0, beq_o=12.0, ncoef_o=2, start_o one-cycle pulse next cycle.
REQ-022 Then done_i=1 with sol_i={40000000,40400000}, m_ready_i=1 -> m_data_o 40000000 then 40400000 (m_last_o=1), back to LOAD.
REQ-023 m_ready_i held 0 three cycles during SEND -> m_data_o/m_last_o unchanged, no word lost.
REQ-024 s_last_i on word 5 -> err_o pulse, no start_o, next full frame loads correctly.
REQ-025 Header ncoef=3 -> err_o after word 12, no start_o; 15-word frame with last on word 14 -> err_o at word 12, words 13-14 discarded.
REQ-026 rst_i asserted mid-SEND after first word -> all outputs zero, s_ready_o=1, new frame accepted.
